cipher_channel_arbiter: RTL

CIPHER_CHANNEL_ARBITER -- requirements
Module: cipher_channel_arbiter

---
 rtl/cipher_arb_pkg.sv | 23 ++
 rtl/rr_arbiter2.sv | 36 +++
 rtl/cipher_channel_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cipher_arb_pkg.sv
// Shared state encoding, letter-range constants and timeout default
// for the two-channel cipher arbiter.
package cipher_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam logic [7:0] UPPER_LO = 8'h41;
  localparam logic [7:0] UPPER_HI = 8'h5A;
  localparam logic [7:0] LOWER_LO = 8'h61;
  localparam logic [7:0] LOWER_HI = 8'h7A;

  localparam int DEFAULT_TIMEOUT_CYCLES = 15;

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= UPPER_LO) && (c <= UPPER_HI)) ||
           ((c >= LOWER_LO) && (c <= LOWER_HI));
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter: the last accepted requester drops
// to lowest priority; requester 0 leads after reset.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic prio_r;

  // One-hot grant, priority index first, then the other requester
  always_comb begin
    grant = 2'b00;
    if (req[prio_r]) begin
      grant[prio_r] = 1'b1;
    end else if (req[~prio_r]) begin
      grant[~prio_r] = 1'b1;
    end else begin
      grant = 2'b00;
    end
  end

  // Priority pointer moves away from the channel just accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_r <= 1'b0;
    end else if (accept) begin
      prio_r <= grant[0];
    end else begin
      prio_r <= prio_r;
    end
  end

endmodule

// File: rtl/cipher_channel_arbiter.sv
// Shares one stream-cipher core between two channels, one request in
// flight; non-letters bypass the core straight into the output buffer.
module cipher_channel_arbiter
  import cipher_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ch0_in_valid,
  input  logic [7:0]  ch0_in_char,
  input  logic [7:0]  ch0_key,
  output logic        ch0_in_ready,
  output logic        ch0_out_valid,
  output logic [7:0]  ch0_out_char,
  input  logic        ch0_out_ready,
  input  logic        ch1_in_valid,
  input  logic [7:0]  ch1_in_char,
  input  logic [7:0]  ch1_key,
  output logic        ch1_in_ready,
  output logic        ch1_out_valid,
  output logic [7:0]  ch1_out_char,
  input  logic        ch1_out_ready,
  output logic        core_din_valid,
  output logic [7:0]  core_key,
  output logic [7:0]  core_char_in,
  input  logic [7:0]  core_char_out,
  input  logic        core_dout_ready,
  output logic        err_timeout,
  output logic [15:0] ch0_count,
  output logic [15:0] ch1_count
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t        state_r, state_nxt_s;
  logic [1:0]        in_valid_s, out_ready_s, req_s, grant_s, wr_en_s, handshake_s;
  logic [1:0]        buf_full_r;
  logic [1:0][7:0]   buf_data_r;
  logic [1:0][15:0]  count_r;
  logic              accept_s, acc_chan_s, acc_letter_s, capture_s, timeout_hit_s;
  logic [7:0]        acc_char_s, acc_key_s, wr_data_s;
  logic              chan_r, core_din_valid_r, err_timeout_r;
  logic [7:0]        core_key_r, core_char_r;
  logic [CNT_W-1:0]  wait_cnt_r;

  assign in_valid_s  = {ch1_in_valid, ch0_in_valid};
  assign out_ready_s = {ch1_out_ready, ch0_out_ready};
  // Full buffers are never granted, and nothing is offered while in reset
  assign req_s       = in_valid_s & ~buf_full_r & {2{(state_r == IDLE) && !rst}};

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (req_s),
    .accept (accept_s),
    .grant  (grant_s)
  );

  assign accept_s      = |grant_s;
  assign acc_chan_s    = grant_s[1];
  assign acc_char_s    = acc_chan_s ? ch1_in_char : ch0_in_char;
  assign acc_key_s     = acc_chan_s ? ch1_key : ch0_key;
  assign acc_letter_s  = is_letter(acc_char_s);
  assign capture_s     = (state_r == WAIT) && core_dout_ready;
  assign timeout_hit_s = (state_r == WAIT) && !core_dout_ready && (wait_cnt_r == CNT_LAST);
  assign handshake_s   = buf_full_r & out_ready_s;

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && acc_letter_s) state_nxt_s = ISSUE;
        else                          state_nxt_s = IDLE;
      end
      ISSUE: state_nxt_s = WAIT;
      WAIT: begin
        if (capture_s || timeout_hit_s) state_nxt_s = IDLE;
        else                            state_nxt_s = WAIT;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Output-buffer write select: core result in WAIT, raw char on bypass
  always_comb begin
    wr_en_s   = 2'b00;
    wr_data_s = acc_char_s;
    if (capture_s) begin
      wr_en_s[chan_r] = 1'b1;
      wr_data_s       = core_char_out;
    end else if (accept_s && !acc_letter_s) begin
      wr_en_s = grant_s;
    end else begin
      wr_en_s = 2'b00;
    end
  end

  // Core request registers, WAIT counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_din_valid_r <= 1'b0;
      core_key_r       <= 8'h00;
      core_char_r      <= 8'h00;
      chan_r           <= 1'b0;
      wait_cnt_r       <= '0;
      err_timeout_r    <= 1'b0;
    end else begin
      core_din_valid_r <= 1'b0;
      if ((state_r == IDLE) && accept_s && acc_letter_s) begin
        core_din_valid_r <= 1'b1;
        core_key_r       <= acc_key_s;
        core_char_r      <= acc_char_s;
        chan_r           <= acc_chan_s;
      end
      if (state_r == WAIT) wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      else                 wait_cnt_r <= '0;
      if (timeout_hit_s) err_timeout_r <= 1'b1;
    end
  end

  // One-entry output buffers and delivered-result counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_full_r <= 2'b00;
      buf_data_r <= '0;
      count_r    <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (wr_en_s[n]) begin
          buf_full_r[n] <= 1'b1;
          buf_data_r[n] <= wr_data_s;
        end else if (handshake_s[n]) begin
          buf_full_r[n] <= 1'b0;
        end
        if (handshake_s[n]) count_r[n] <= count_r[n] + 16'd1;
      end
    end
  end

  assign ch0_in_ready   = grant_s[0];
  assign ch1_in_ready   = grant_s[1];
  assign ch0_out_valid  = buf_full_r[0];
  assign ch1_out_valid  = buf_full_r[1];
  assign ch0_out_char   = buf_data_r[0];
  assign ch1_out_char   = buf_data_r[1];
  assign ch0_count      = count_r[0];
  assign ch1_count      = count_r[1];
  assign core_din_valid = core_din_valid_r;
  assign core_key       = core_key_r;
  assign core_char_in   = core_char_r;
  assign err_timeout    = err_timeout_r;

endmodule
